// File: rtl/pll_lock_reset_ctrl.sv
// pll_lock_reset_ctrl
//
// Qualifies the raw PLL lock and generates the sequenced system resets. The
// peripheral/SDRAM reset is released first, once lock has been stable for
// STABLE_CYCLES. The CPU reset follows CPU_DELAY cycles later.
//
// While running, a lock-low run of LOSS_FILTER cycles counts as a lock loss.
// A loss re-asserts both resets and restarts the whole sequence. Each loss
// event is recorded in a sticky flag and in a saturating counter.
//
// Ports:
//   clk          PLL output clock; all logic runs on the rising edge
//   rst_n        asynchronous active-low board reset
//   pll_lock     raw PLL lock, asynchronous to clk
//   clear_lost   synchronous pulse that clears lock_lost
//   periph_rst_n active-low reset for the SDRAM controller and peripherals
//   cpu_rst_n    active-low reset for the CPU core
//   ready        high while both resets are released
//   lock_lost    sticky lock-loss flag
//   loss_count   saturating count of lock-loss events
module pll_lock_reset_ctrl #(
  parameter int STABLE_CYCLES = 1024,
  parameter int CPU_DELAY     = 256,
  parameter int LOSS_FILTER   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       clear_lost,
  output logic       periph_rst_n,
  output logic       cpu_rst_n,
  output logic       ready,
  output logic       lock_lost,
  output logic [7:0] loss_count
);

  // One counter is shared by the lock-stable wait and the CPU delay,
  // so it is sized for whichever of the two is longer.
  localparam int CNT_MAX = (STABLE_CYCLES > CPU_DELAY) ? STABLE_CYCLES : CPU_DELAY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LOW_W   = $clog2(LOSS_FILTER + 1);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CPU_LAST    = CNT_W'(CPU_DELAY - 1);
  localparam logic [LOW_W-1:0] LOW_LAST    = LOW_W'(LOSS_FILTER - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    PERIPH,
    RUN
  } state_t;

  state_t           state;
  logic             lock_meta;
  logic             lock_s;
  logic [CNT_W-1:0] cnt;
  logic [LOW_W-1:0] low_cnt;
  logic             loss_event;

  // Two-flop synchronizer for the asynchronous lock input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  // A loss is only recognised once the resets have started releasing.
  // While in WAIT_LOCK, a missing lock simply keeps the system held.
  assign loss_event = (state != WAIT_LOCK) && !lock_s && (low_cnt == LOW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      low_cnt      <= '0;
      periph_rst_n <= 1'b0;
      cpu_rst_n    <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      loss_count   <= 8'd0;
    end else begin
      // The clear is applied first, so a loss event on the same edge overrides it.
      if (clear_lost) begin
        lock_lost <= 1'b0;
      end

      case (state)
        WAIT_LOCK: begin
          low_cnt <= '0;
          if (!lock_s) begin
            cnt <= '0;
          end else if (cnt == STABLE_LAST) begin
            state        <= PERIPH;
            cnt          <= '0;
            periph_rst_n <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        PERIPH, RUN: begin
          if (loss_event) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            low_cnt      <= '0;
            periph_rst_n <= 1'b0;
            cpu_rst_n    <= 1'b0;
            ready        <= 1'b0;
            lock_lost    <= 1'b1;
            if (loss_count != 8'hFF) begin
              loss_count <= loss_count + 8'd1;
            end
          end else begin
            low_cnt <= lock_s ? '0 : low_cnt + 1'b1;
            if (state == PERIPH) begin
              if (cnt == CPU_LAST) begin
                state     <= RUN;
                cnt       <= '0;
                cpu_rst_n <= 1'b1;
                ready     <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
        end

        default: state <= WAIT_LOCK;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_ctrl.sv
// tb_pll_lock_reset_ctrl
//
// Bench for pll_lock_reset_ctrl with small sequencing parameters.
// Expected output vectors are queued with the edge number at which they must
// hold. A negedge monitor pops each entry when that edge arrives and checks
// the DUT against it.
module tb_pll_lock_reset_ctrl;

  localparam int STABLE = 16;
  localparam int DELAY  = 8;
  localparam int FILTER = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       clear_lost;
  logic       periph_rst_n;
  logic       cpu_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [7:0] loss_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int edge_cnt     = 0;

  typedef struct {
    int          at_edge;
    string       tag;
    logic [11:0] vec;
  } exp_t;

  exp_t exp_q[$];

  pll_lock_reset_ctrl #(
    .STABLE_CYCLES(STABLE),
    .CPU_DELAY    (DELAY),
    .LOSS_FILTER  (FILTER)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .clear_lost  (clear_lost),
    .periph_rst_n(periph_rst_n),
    .cpu_rst_n   (cpu_rst_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .loss_count  (loss_count)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  // Number of rising edges seen so far, read on the falling edge.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Output vector layout: {periph_rst_n, cpu_rst_n, ready, lock_lost, loss_count}.
  function automatic logic [11:0] mk(input bit p, input bit c, input bit r,
                                     input bit l, input int n);
    return {p, c, r, l, 8'(n)};
  endfunction

  function automatic logic [11:0] observed();
    return {periph_rst_n, cpu_rst_n, ready, lock_lost, loss_count};
  endfunction

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Queues one expectation. Entries must be pushed in edge order.
  task automatic pushExpect(input int e, input string tag, input logic [11:0] v);
    exp_t item;
    item.at_edge = e;
    item.tag     = tag;
    item.vec     = v;
    exp_q.push_back(item);
  endtask

  // Drives the two synchronous inputs. Callers invoke it just after a falling edge.
  task automatic applyStimulus(input logic lock_v, input logic clr_v);
    pll_lock   = lock_v;
    clear_lost = clr_v;
  endtask

  task automatic waitEdges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits, with a bound, until every queued expectation has been checked.
  task automatic drainQueue();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor: compares each queued entry at its edge.
  always @(negedge clk) begin : monitor
    exp_t cur;
    while (exp_q.size() > 0 && exp_q[0].at_edge <= edge_cnt) begin
      cur = exp_q.pop_front();
      if (cur.at_edge < edge_cnt)
        checkOutput({cur.tag, "_missed"}, 32'(edge_cnt), 32'(cur.at_edge));
      else
        checkOutput(cur.tag, {20'd0, observed()}, {20'd0, cur.vec});
    end
  end

  initial begin : main
    int t;
    int prev_cnt;
    int next_cnt;

    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    #3 rst_n = 1'b0;
    #1 checkOutput("reset_state", {20'd0, observed()}, {20'd0, mk(0, 0, 0, 0, 0)});
    waitEdges(3);

    // Basic power-up sequence with lock present before edge 1.
    t = edge_cnt;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
    pushExpect(t + 17, "seq_pre_periph", mk(0, 0, 0, 0, 0));
    pushExpect(t + 18, "seq_periph",     mk(1, 0, 0, 0, 0));
    pushExpect(t + 25, "seq_pre_cpu",    mk(1, 0, 0, 0, 0));
    pushExpect(t + 26, "seq_run",        mk(1, 1, 1, 0, 0));
    drainQueue();

    // Asynchronous reset while running.
    waitEdges(2);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_run", {20'd0, observed()}, {20'd0, mk(0, 0, 0, 0, 0)});

    // A lock dropout during the stable wait restarts the count.
    @(negedge clk);
    t = edge_cnt;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0);
    pushExpect(t + 12, "dropout_wait",     mk(0, 0, 0, 0, 0));
    pushExpect(t + 30, "dropout_pre",      mk(0, 0, 0, 0, 0));
    pushExpect(t + 31, "dropout_periph",   mk(1, 0, 0, 0, 0));
    pushExpect(t + 38, "dropout_pre_cpu",  mk(1, 0, 0, 0, 0));
    pushExpect(t + 39, "dropout_run",      mk(1, 1, 1, 0, 0));
    waitEdges(10);
    applyStimulus(1'b0, 1'b0);
    waitEdges(3);
    applyStimulus(1'b1, 1'b0);
    drainQueue();

    // A 3-cycle glitch in RUN is filtered out.
    t = edge_cnt;
    applyStimulus(1'b0, 1'b0);
    for (int k = 3; k <= 7; k++) pushExpect(t + k, "glitch_run", mk(1, 1, 1, 0, 0));
    waitEdges(3);
    applyStimulus(1'b1, 1'b0);
    drainQueue();

    // A real loss in RUN, followed by a re-lock.
    waitEdges(2);
    t = edge_cnt;
    applyStimulus(1'b0, 1'b0);
    pushExpect(t + 5, "loss_pre",   mk(1, 1, 1, 0, 0));
    pushExpect(t + 6, "loss_event", mk(0, 0, 0, 1, 1));
    pushExpect(t + 9, "loss_hold",  mk(0, 0, 0, 1, 1));
    waitEdges(9);
    t = edge_cnt;
    applyStimulus(1'b1, 1'b0);
    pushExpect(t + 17, "relock_pre",     mk(0, 0, 0, 1, 1));
    pushExpect(t + 18, "relock_periph",  mk(1, 0, 0, 1, 1));
    pushExpect(t + 25, "relock_pre_cpu", mk(1, 0, 0, 1, 1));
    pushExpect(t + 26, "relock_run",     mk(1, 1, 1, 1, 1));
    drainQueue();

    // clear_lost clears the flag but not the counter.
    t = edge_cnt;
    applyStimulus(1'b1, 1'b1);
    pushExpect(t + 1, "clear_lost", mk(1, 1, 1, 0, 1));
    waitEdges(1);
    applyStimulus(1'b1, 1'b0);
    pushExpect(t + 3, "clear_hold", mk(1, 1, 1, 0, 1));
    drainQueue();

    // A loss event on the same edge as clear_lost: the set wins.
    t = edge_cnt;
    applyStimulus(1'b0, 1'b0);
    pushExpect(t + 5, "coincide_pre", mk(1, 1, 1, 0, 1));
    waitEdges(5);
    applyStimulus(1'b0, 1'b1);
    pushExpect(t + 6, "set_wins", mk(0, 0, 0, 1, 2));
    waitEdges(1);
    applyStimulus(1'b0, 1'b0);
    drainQueue();

    // Repeated losses from PERIPH drive loss_count into saturation.
    for (int i = 0; i < 298; i++) begin
      prev_cnt = (2 + i > 255) ? 255 : 2 + i;
      next_cnt = (3 + i > 255) ? 255 : 3 + i;
      t = edge_cnt;
      applyStimulus(1'b1, 1'b0);
      pushExpect(t + 18, "sat_periph", mk(1, 0, 0, 1, prev_cnt));
      waitEdges(18);
      applyStimulus(1'b0, 1'b0);
      pushExpect(t + 24, "sat_loss", mk(0, 0, 0, 1, next_cnt));
      waitEdges(6);
    end
    drainQueue();

    // Asynchronous reset in the middle of PERIPH clears everything.
    t = edge_cnt;
    applyStimulus(1'b1, 1'b0);
    pushExpect(t + 18, "mid_periph", mk(1, 0, 0, 1, 255));
    waitEdges(20);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_periph", {20'd0, observed()}, {20'd0, mk(0, 0, 0, 0, 0)});
    drainQueue();

    // Without lock the controller stays in WAIT_LOCK and counts no losses.
    @(negedge clk);
    t = edge_cnt;
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0);
    pushExpect(t + 20, "no_lock_20", mk(0, 0, 0, 0, 0));
    pushExpect(t + 40, "no_lock_40", mk(0, 0, 0, 0, 0));
    drainQueue();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pll_lock_reset_ctrl.md
Name: pll_lock_reset_ctrl

Overview:
- Consumes the PLL `lock` output in the PLL output clock domain and produces the sequenced, lock-qualified resets for the design.
- Release order: peripheral/SDRAM-controller reset first, CPU reset after a fixed delay.
- Monitors lock during operation, re-asserts both resets on a filtered lock loss, and records loss events for debug.

Parameters:
- STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before `periph_rst_n` is released (≥1).
- CPU_DELAY, 256: cycles from `periph_rst_n` release to `cpu_rst_n` release (≥1).
- LOSS_FILTER, 4: consecutive synchronized-lock-low cycles that constitute a lock loss (≥1).

Ports:
- clk  input  1  PLL output clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset (board button).
- pll_lock  input  1  raw PLL lock, asynchronous to clk.
- clear_lost  input  1  synchronous pulse; clears the sticky `lock_lost`.
- periph_rst_n  output  1  active-low reset for SDRAM controller and peripherals.
- cpu_rst_n  output  1  active-low reset for the CPU core.
- ready  output  1  high when both resets are released (state RUN).
- lock_lost  output  1  sticky flag; set on each lock-loss event.
- loss_count  output  8  saturating count of lock-loss events.

Behaviour:
- Reset (`rst_n` low, asynchronous): all of the following are forced immediately.
  - `periph_rst_n`=0, `cpu_rst_n`=0, `ready`=0, `lock_lost`=0, `loss_count`=0.
  - Synchronizer flops = 0, counters = 0, state = WAIT_LOCK.
  - All outputs are registered. Deassertion of the internal resets is always synchronous to `clk`.
- Synchronizer: `pll_lock` passes through 2 flops to produce `lock_s`. `lock_s` reflects `pll_lock` after edge 2.
- State WAIT_LOCK (both resets asserted, `ready`=0):
  - `cnt` increments on each edge with `lock_s`=1 and clears to 0 on any edge with `lock_s`=0.
  - On an edge with `lock_s`=1 and `cnt`==STABLE_CYCLES-1: go to PERIPH, clear `cnt`, set `periph_rst_n`=1 at that same edge.
- State PERIPH (`periph_rst_n`=1, `cpu_rst_n`=0):
  - `cnt` increments every edge.
  - On an edge with `cnt`==CPU_DELAY-1: go to RUN, set `cpu_rst_n`=1 and `ready`=1 at that same edge.
- State RUN: both resets released, `ready`=1. Holds until a loss event.
- Loss filter (active in PERIPH and RUN):
  - `low_cnt` increments on each edge with `lock_s`=0 and clears on any edge with `lock_s`=1.
  - On an edge with `lock_s`=0 and `low_cnt`==LOSS_FILTER-1 (a loss event), all of the following happen at that same edge:
    - Go to WAIT_LOCK.
    - `periph_rst_n`=0, `cpu_rst_n`=0, `ready`=0.
    - `cnt`=0, `low_cnt`=0.
    - `lock_lost`=1, and `loss_count` increments (saturates at 255).
  - A low excursion of LOSS_FILTER-1 or fewer cycles is ignored: no output change.
  - A loss event in PERIPH before the CPU is released follows the same rules.
- `clear_lost`:
  - Clears `lock_lost` on the next edge.
  - If it coincides with a loss event, set wins (`lock_lost`=1).
  - Has no effect on `loss_count`; only `rst_n` clears `loss_count`.
- Re-lock after a loss follows the full WAIT_LOCK → PERIPH → RUN sequence, with the same counts.
- `pll_lock` held low forever: remain in WAIT_LOCK with resets asserted; no loss events are counted in WAIT_LOCK.
- `rst_n` asserted mid-sequence: immediate return to reset values, including `loss_count`=0 and `lock_lost`=0.

Test Plan:
- STABLE_CYCLES=16, CPU_DELAY=8, LOSS_FILTER=4; release `rst_n`, raise `pll_lock` before edge 1 → `periph_rst_n` rises at edge 18; `cpu_rst_n` and `ready` rise at edge 26; `loss_count`=0.
- Same setup, `pll_lock` drops for 3 cycles at edge 10 (`lock_s` low at edges 12–14), then returns high → `cnt` restarts and `periph_rst_n` rises 16 `lock_s`-high edges later, at edge 31.
- In RUN, drop `pll_lock` for 3 cycles → no change, `ready` stays 1. Then drop it for 4+ cycles → at the 4th `lock_s`-low edge: both resets 0, `ready`=0, `lock_lost`=1, `loss_count`=1. Restore lock → full re-sequence (16 + 8 cycles).
- Pulse `clear_lost` with `lock_lost`=1 → `lock_lost`=0 next edge, `loss_count` unchanged. Pulse `clear_lost` on the same edge as a loss event → `lock_lost`=1.
- Force 300 loss events → `loss_count` saturates at 255, no wrap.
- Assert `rst_n` low mid-PERIPH (asynchronously, between edges) → `periph_rst_n`=0, `ready`=0, `loss_count`=0 immediately, with no clock edge needed.
